// File: rtl/serv_rst_pkg.sv
// serv_rst_pkg: shared types and constants for the SERV reset sequencer.
//   state_t  - sequencer states HOLD -> LOCK -> PERIPH -> RUN
//   cause_t  - encoding of the reset-entry cause reported on o_cause
//   max3     - helper used to size the shared stage counter
package serv_rst_pkg;

    typedef enum logic [1:0] {
        HOLD,
        LOCK,
        PERIPH,
        RUN
    } state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR       = 2'd0;
    localparam cause_t CAUSE_SOFT      = 2'd1;
    localparam cause_t CAUSE_LOCK_LOST = 2'd2;
    localparam cause_t CAUSE_WDT       = 2'd3;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serv_reset_ctrl_if.sv
// serv_reset_ctrl_if: signal bundle between the reset sequencer and its
// surroundings (PLL lock, soft reset and watchdog kick in; resets, ready
// and reset cause out).
//   master - environment side: drives the request inputs, observes outputs
//   slave  - sequencer side: observes the requests, drives the outputs
interface serv_reset_ctrl_if;
    import serv_rst_pkg::*;

    logic   i_pll_locked;
    logic   i_soft_rst;
    logic   i_wdt_kick;
    logic   o_rst_periph;
    logic   o_rst_core;
    logic   o_ready;
    cause_t o_cause;

    modport master (
        output i_pll_locked, i_soft_rst, i_wdt_kick,
        input  o_rst_periph, o_rst_core, o_ready, o_cause
    );

    modport slave (
        input  i_pll_locked, i_soft_rst, i_wdt_kick,
        output o_rst_periph, o_rst_core, o_ready, o_cause
    );

endinterface

// File: rtl/serv_rst_sync.sv
// serv_rst_sync: two-flop synchronizer bringing an asynchronous level into
// the i_clk domain. Both flops clear to 0 while i_rst_n is low.
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low clear
//   i_d     - asynchronous input level
//   o_q     - synchronized level (two-cycle latency)
module serv_rst_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/serv_reset_ctrl.sv
// serv_reset_ctrl: reset sequencer for the SERV clock/reset domain.
// After power-on it holds both resets, waits for a stable synchronized PLL
// lock, then releases the peripheral reset before the core reset. Lock loss,
// a soft-reset request in RUN or (optionally) a watchdog timeout re-enter
// HOLD and record the cause.
//   i_clk    - single clock, all outputs registered on its rising edge
//   i_rst_n  - asynchronous active-low reset
//   bus      - serv_reset_ctrl_if.slave: i_pll_locked, i_soft_rst,
//              i_wdt_kick in; o_rst_periph, o_rst_core, o_ready, o_cause out
// Build option: define SERV_RST_WDT_EN to include the RUN-state watchdog.
module serv_reset_ctrl
    import serv_rst_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned LOCK_CYCLES  = 16,
    parameter int unsigned STAGE_CYCLES = 4,
    parameter int unsigned WDT_CYCLES   = 1024
) (
    input logic              i_clk,
    input logic              i_rst_n,
    serv_reset_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(max3(HOLD_CYCLES, LOCK_CYCLES, STAGE_CYCLES) + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    cause_t        cause_q, cause_d;
    logic          periph_q, periph_d;
    logic          core_q, core_d;
    logic          ready_q, ready_d;
    logic          locked_s;
    logic          wdt_expire;
    logic          go_hold;

    serv_rst_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (bus.i_pll_locked),
        .o_q     (locked_s)
    );

`ifdef SERV_RST_WDT_EN
    localparam int unsigned WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wdt_q, wdt_d;

    // A kick on the terminal cycle cancels the timeout.
    assign wdt_expire = (state_q == RUN) && (wdt_q == WDT_LAST) && !bus.i_wdt_kick;

    always_comb begin
        wdt_d = '0;
        if (state_q == RUN && state_d == RUN)
            wdt_d = bus.i_wdt_kick ? '0 : wdt_q + WW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            wdt_q <= '0;
        else
            wdt_q <= wdt_d;
    end
`else
    logic unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = bus.i_wdt_kick ^ (WDT_CYCLES == 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        go_hold = 1'b0;

        unique case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOCK: begin
                // Any low sample restarts the stability window.
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PERIPH: begin
                if (!locked_s) begin
                    go_hold = 1'b1;
                    cause_d = CAUSE_LOCK_LOST;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                // Priority: lock loss, then watchdog, then soft reset.
                if (!locked_s) begin
                    go_hold = 1'b1;
                    cause_d = CAUSE_LOCK_LOST;
                end else if (wdt_expire) begin
                    go_hold = 1'b1;
                    cause_d = CAUSE_WDT;
                end else if (bus.i_soft_rst) begin
                    go_hold = 1'b1;
                    cause_d = CAUSE_SOFT;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase

        if (go_hold) begin
            state_d = HOLD;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state and registered, so the
        // ports only ever see flop outputs.
        periph_d = (state_d == HOLD) || (state_d == LOCK);
        core_d   = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            cause_q  <= CAUSE_POR;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.o_rst_periph = periph_q;
    assign bus.o_rst_core   = core_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_cause      = cause_q;

endmodule
